// File: rtl/bcd7seg_pkg.sv
// rtl/bcd7seg_pkg.sv - seven-segment pattern constants and segment vector type
package bcd7seg_pkg;

  // Segment vector {a,b,c,d,e,f,g}, a in the MSB, 1 = segment lit
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd7seg_scan_if.sv
// rtl/bcd7seg_scan_if.sv - display data inputs and scanned display outputs
interface bcd7seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  import bcd7seg_pkg::*;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    lzs_en;
  seg_t                    seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output load, value, blank_mask, dp_mask, lzs_en,
    input  seg, dp_out, an, frame_done
  );

  modport slave (
    input  load, value, blank_mask, dp_mask, lzs_en,
    output seg, dp_out, an, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high segment decode
module seg7_hex_decode
  import bcd7seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Full hex table, lowercase b and d shapes for 0xB and 0xD
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd7seg_scan.sv
// rtl/bcd7seg_scan.sv - multiplexed hex seven-segment display scanner
module bcd7seg_scan
  import bcd7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst,
  bcd7seg_scan_if.slave  bus
);

  localparam int              CW        = $clog2(CLK_DIV);
  localparam int              IW        = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]   IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam seg_t            SEG_UNLIT = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic            DP_UNLIT  = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
  logic                    out_en_q, out_en_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic [3:0]              nib;
  logic                    blank_sel;
  logic                    dp_sel;
  logic                    suppress;
  logic                    all_zero;
  logic                    dark;
  seg_t                    seg_pat;
  seg_t                    seg_lit;
  logic                    dp_lit;

  // Prescaler and digit index; frame_done marks the tick that ends the last slot
  always_comb begin
    tick           = (cnt_q == CNT_MAX);
    cnt_d          = tick ? '0 : cnt_q + CW'(1);
    idx_d          = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    bus.frame_done = tick && (idx_q == IDX_MAX);
  end

  // Shadow registers follow the inputs only on a load strobe
  always_comb begin
    value_d = value_q;
    blank_d = blank_q;
    dpm_d   = dpm_q;
    if (bus.load) begin
      value_d = bus.value;
      blank_d = bus.blank_mask;
      dpm_d   = bus.dp_mask;
    end
  end

  // Select the active digit and work out whether it sits in a run of leading zeros
  always_comb begin
    nib       = 4'h0;
    blank_sel = 1'b0;
    dp_sel    = 1'b0;
    suppress  = 1'b0;
    all_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (value_q[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k)) begin
        nib       = value_q[4*k +: 4];
        blank_sel = blank_q[k];
        dp_sel    = dpm_q[k];
        suppress  = all_zero && (k > 0);
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble (nib),
    .seg    (seg_pat)
  );

  // Blanking, then output polarity; a suppressed digit keeps its decimal point
  always_comb begin
    dark     = blank_sel || (bus.lzs_en && suppress);
    seg_lit  = dark ? SEG_BLANK : seg_pat;
    dp_lit   = dp_sel && !blank_sel;
    out_en_d = 1'b1;
    seg_d    = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    dp_d     = (SEG_ACTIVE_LOW != 0) ? ~dp_lit : dp_lit;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[k] = (idx_q != IW'(k));
    end
    if (!out_en_q) begin
      seg_d = SEG_UNLIT;
      dp_d  = DP_UNLIT;
      an_d  = '1;
    end
  end

  // State and registered display outputs; out_en holds the display dark one extra cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      value_q  <= '0;
      blank_q  <= '0;
      dpm_q    <= '0;
      out_en_q <= 1'b0;
      seg_q    <= SEG_UNLIT;
      dp_q     <= DP_UNLIT;
      an_q     <= '1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      blank_q  <= blank_d;
      dpm_q    <= dpm_d;
      out_en_q <= out_en_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.dp_out = dp_q;
  assign bus.an     = an_q;

endmodule

// File: doc/bcd7seg_scan.md
BCD7SEG_SCAN -- requirements
Module: bcd7seg_scan

Interface
- REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
- REQ-002 Parameter CLK_DIV, default 50000: clock cycles per digit slot, minimum 2.
- REQ-003 Parameter SEG_ACTIVE_LOW, default 1: 1 inverts seg and dp_out so a lit segment drives 0.
- REQ-004 clk  in  1  sole clock; all logic on rising edge.
- REQ-005 rst  in  1  synchronous, active-high reset.
- REQ-006 load  in  1  capture strobe; when 1, value, blank_mask and dp_mask are sampled.
- REQ-007 value  in  4*NUM_DIGITS  nibble k is digit k; digit 0 is least significant.
- REQ-008 blank_mask  in  NUM_DIGITS  bit k=1 forces digit k dark.
- REQ-009 dp_mask  in  NUM_DIGITS  bit k=1 lights the decimal point of digit k.
- REQ-010 lzs_en  in  1  leading-zero suppression enable; not latched, used live.
- REQ-011 seg  out  7  segments {a,b,c,d,e,f,g}, a is MSB.
- REQ-012 dp_out  out  1  decimal point of the active digit.
- REQ-013 an  out  NUM_DIGITS  digit enables, active-low, one-hot-cold.
- REQ-014 frame_done  out  1  one-cycle pulse when the last digit slot ends.

Function
- REQ-015 A prescaler shall count 0..CLK_DIV-1 and wrap; tick asserts in the cycle the count equals CLK_DIV-1.
- REQ-016 On tick the digit index shall advance by 1, wrapping from NUM_DIGITS-1 to 0.
- REQ-017 frame_done shall assert for exactly one cycle, the cycle in which tick occurs with index NUM_DIGITS-1.
- REQ-018 When load=1, the shadow registers shall take value, blank_mask and dp_mask at that edge; new data is displayed from the next cycle. A load coinciding with tick is not lost.
- REQ-019 Nibble decode shall be full hex: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- REQ-020 With lzs_en=1, digit k shall be dark when digits NUM_DIGITS-1..k are all zero and k>0; digit 0 is never suppressed.
- REQ-021 A dark digit (blank_mask or suppression) shall drive seg=0000000 and dp_out=0 logically, with its an bit still asserted; a suppressed digit with dp_mask set shall still light dp_out.
- REQ-022 seg, dp_out and an shall be registered; they reflect the index and shadow state of the previous cycle (1-cycle latency).
- REQ-023 an shall have exactly one bit low at all times outside reset, bit index = displayed digit.
- REQ-024 SEG_ACTIVE_LOW polarity shall apply to seg and dp_out only, after blanking.

Reset
- REQ-025 On rst=1: prescaler 0, index 0, shadow value/blank_mask/dp_mask 0, frame_done 0.
- REQ-026 During reset and the first cycle after it, an shall be all ones and seg/dp_out shall be at the unlit level.
- REQ-027 rst shall override load in the same cycle; reset mid-frame restarts the scan at digit 0.

Structure
- REQ-028 Package bcd7seg_pkg shall hold the 16 segment-pattern constants, SEG_BLANK, and the segment-vector typedef.
- REQ-029 Decoding shall be in a combinational sub-module seg7_hex_decode (nibble in, 7-bit active-high pattern out), instantiated once on the muxed nibble.

Verification
- REQ-030 Reset: assert rst 3 cycles -> an=1111, frame_done=0; first tick at cycle CLK_DIV after release.
- REQ-031 CLK_DIV=4, load value=0x1234 -> an sequence 1110,1101,1011,0111 every 4 cycles, seg 0110011,1111001,1101101,0110000 (active-low inverted), frame_done once per 16 cycles.
- REQ-032 lzs_en=1, value=0x0040 -> digits 3,2 dark, digit 1 shows 4, digit 0 shows 0; value=0x0000 -> only digit 0 lit.
- REQ-033 blank_mask=0010, dp_mask=0100, value=0x8888 -> digit 1 dark, dp_out lit only in digit 2 slot.
- REQ-034 load asserted in the tick cycle with value 0xABCD -> following slot shows new data; hex A..F patterns match REQ-019.
- REQ-035 rst asserted mid-frame at index 2 -> next post-reset slot is digit 0, shadow cleared, displays 0.
